pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage core (IF/ID/EXE/MEM/WB).

---
 rtl/pipeline_ctrl_pkg.sv | 55 +++++
 rtl/hazard_detect.sv | 33 +++
 rtl/pipeline_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage core stall/flush sequencer: FSM encoding,
// per-stage control bundle and the mode-to-controls mapping.
package pipeline_ctrl_pkg;

  localparam int unsigned RA_DEF    = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_HAZ     = 2'd1,
    PC_MEMWAIT = 2'd2,
    PC_REDIR   = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
    logic flush;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input pc_state_e s);
    ctrl_t c;
    c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
          id_ex_bubble: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
          mem_wb_bubble: 1'b0, flush: 1'b0};
    case (s)
      PC_MEMWAIT: begin
        c.pc_en         = 1'b0;
        c.if_id_en      = 1'b0;
        c.id_ex_en      = 1'b0;
        c.ex_mem_en     = 1'b0;
        c.mem_wb_bubble = 1'b1;
      end
      PC_REDIR: begin
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = 1'b1;
        c.flush        = 1'b1;
      end
      PC_HAZ: begin
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Data-hazard detector: a decode source collides with any valid in-flight
// destination tag; register 0 never causes a stall.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_SIZE = RA_DEF
) (
  input  logic [REG_ADDR_SIZE:0] rs1,
  input  logic [REG_ADDR_SIZE:0] rs2,
  input  logic [REG_ADDR_SIZE:0] rd_id,
  input  logic                   rd_id_v,
  input  logic [REG_ADDR_SIZE:0] rd_exe,
  input  logic                   rd_exe_v,
  input  logic [REG_ADDR_SIZE:0] rd_mem,
  input  logic                   rd_mem_v,
  input  logic [REG_ADDR_SIZE:0] rd_wb,
  input  logic                   rd_wb_v,
  output logic                   stall
);

  function automatic logic src_hit(input logic [REG_ADDR_SIZE:0] rs);
    return (rs != '0) &&
           ((rd_id_v  && (rs == rd_id))  ||
            (rd_exe_v && (rs == rd_exe)) ||
            (rd_mem_v && (rs == rd_mem)) ||
            (rd_wb_v  && (rs == rd_wb)));
  endfunction

  always_comb begin
    stall = src_hit(rs1) || src_hit(rs2);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the IF/ID/EXE/MEM/WB core: tracks in-flight
// destination tags, arbitrates mem wait > redirect > hazard, counts stalls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_SIZE = RA_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_SIZE:0] id_rs1,
  input  logic [REG_ADDR_SIZE:0] id_rs2,
  input  logic [REG_ADDR_SIZE:0] id_rd,
  input  logic                   id_rd_valid,
  input  logic                   exe_redirect,
  input  logic                   mem_busy,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   mem_wb_bubble,
  output logic                   flush,
  output logic [1:0]             ctrl_state,
  output logic [CNT_W-1:0]       stall_cycles
);

  logic [REG_ADDR_SIZE:0] ex_rd, mem_rd, wb_rd;
  logic                   ex_v, mem_v, wb_v;
  logic                   redir_pend;
  logic                   hz_stall, haz, redir;
  pc_state_e              state, state_next;
  ctrl_t                  ctrl;
  logic [CNT_W-1:0]       stall_cnt;

  // The WB slot is tied off: the register file forwards on writeback.
  hazard_detect #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_hazard (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rd_id    (ex_rd),
    .rd_id_v  (ex_v),
    .rd_exe   (mem_rd),
    .rd_exe_v (mem_v),
    .rd_mem   (wb_rd),
    .rd_mem_v (wb_v),
    .rd_wb    ('0),
    .rd_wb_v  (1'b0),
    .stall    (hz_stall)
  );

  always_comb begin
    haz        = id_valid & hz_stall;
    redir      = exe_redirect | redir_pend;
    state_next = PC_RUN;
    if (mem_busy)   state_next = PC_MEMWAIT;
    else if (redir) state_next = PC_REDIR;
    else if (haz)   state_next = PC_HAZ;
    ctrl = ctrl_for(state_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PC_RUN;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd      <= '0;
      ex_v       <= 1'b0;
      mem_rd     <= '0;
      mem_v      <= 1'b0;
      wb_rd      <= '0;
      wb_v       <= 1'b0;
      redir_pend <= 1'b0;
    end else if (mem_busy) begin
      redir_pend <= redir_pend | exe_redirect;
    end else begin
      wb_rd      <= mem_rd;
      wb_v       <= mem_v;
      mem_rd     <= ex_rd;
      mem_v      <= ex_v;
      ex_rd      <= id_rd;
      // Only an instruction that actually leaves decode (RUN) becomes a tag.
      ex_v       <= (state_next == PC_RUN) & id_valid & id_rd_valid;
      redir_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt <= '0;
    else if (!ctrl.pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign flush         = ctrl.flush;
  assign ctrl_state    = state;
  assign stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: in-flight-instruction model checked every cycle,
// plus directed scenarios with hand-computed stall/flush counts.
module tb_pipeline_ctrl;

  localparam int RA = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rd_valid, exe_redirect, mem_busy;
  logic [RA:0]   id_rs1, id_rs2, id_rd;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic          ex_mem_en, mem_wb_en, mem_wb_bubble, flush;
  logic [1:0]    ctrl_state;
  logic [15:0]   stall_cycles;

  int total = 0;
  int bad   = 0;
  int low_cnt, bub_cnt, mwb_cnt, st2_cnt, fl_cnt;

  pipeline_ctrl #(.REG_ADDR_SIZE(RA), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_valid(id_rd_valid),
    .exe_redirect(exe_redirect), .mem_busy(mem_busy), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .mem_wb_bubble(mem_wb_bubble), .flush(flush), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: three in-flight slots (0=EXE,1=MEM,2=WB), each a dest reg + valid.
  logic [RA:0] m_rd [3];
  bit          m_v  [3];
  bit          m_pend;
  int          m_cnt, m_prev;

  // 0 run, 1 hazard, 2 memory wait, 3 redirect
  function automatic int m_mode();
    bit h = 0;
    for (int k = 0; k < 3; k++)
      if (m_v[k] && ((id_rs1 != 0 && id_rs1 == m_rd[k]) ||
                     (id_rs2 != 0 && id_rs2 == m_rd[k])))
        h = 1;
    if (mem_busy) return 2;
    if (exe_redirect || m_pend) return 3;
    if (h && id_valid) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int md;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_rd[k] <= '0;
        m_v[k]  <= 1'b0;
      end
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_prev <= 0;
    end else begin
      md = m_mode();
      if ((md == 1 || md == 2) && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (!mem_busy) begin
        m_rd[2] <= m_rd[1];  m_v[2] <= m_v[1];
        m_rd[1] <= m_rd[0];  m_v[1] <= m_v[0];
        m_rd[0] <= id_rd;    m_v[0] <= (md == 0) && id_valid && id_rd_valid;
        m_pend  <= 1'b0;
      end else begin
        m_pend <= m_pend | exe_redirect;
      end
      m_prev <= md;
    end
  end

  always @(negedge clk) begin : compare
    int md;
    if (rst_n) begin
      md = m_mode();
      chk("pc_en",         pc_en,         (md == 0 || md == 3));
      chk("if_id_en",      if_id_en,      (md == 0 || md == 3));
      chk("if_id_flush",   if_id_flush,   (md == 3));
      chk("id_ex_en",      id_ex_en,      (md != 2));
      chk("id_ex_bubble",  id_ex_bubble,  (md == 1 || md == 3));
      chk("ex_mem_en",     ex_mem_en,     (md != 2));
      chk("mem_wb_en",     mem_wb_en,     1);
      chk("mem_wb_bubble", mem_wb_bubble, (md == 2));
      chk("flush",         flush,         (md == 3));
      chk("ctrl_state",    ctrl_state,    m_prev);
      chk("stall_cycles",  stall_cycles,  m_cnt);
      if (!pc_en)           low_cnt++;
      if (id_ex_bubble)     bub_cnt++;
      if (mem_wb_bubble)    mwb_cnt++;
      if (ctrl_state == 2)  st2_cnt++;
      if (flush)            fl_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rd_valid = 0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    exe_redirect = 0; mem_busy = 0;
  endtask

  task automatic clr();
    low_cnt = 0; bub_cnt = 0; mwb_cnt = 0; st2_cnt = 0; fl_cnt = 0;
  endtask

  initial begin
    idle();
    clr();
    rst_n = 0;
    step();
    chk("rst_pc_en", pc_en, 1);
    chk("rst_mem_wb_en", mem_wb_en, 1);
    chk("rst_state", ctrl_state, 0);
    chk("rst_cnt", stall_cycles, 0);
    chk("rst_flush", flush, 0);
    step();
    rst_n = 1;
    step();

    // 1: RAW on r5 directly behind its producer -> three stall cycles
    clr();
    id_valid = 1; id_rd = 5; id_rd_valid = 1; step();
    id_rd = 0; id_rd_valid = 0; id_rs1 = 5; repeat (4) step();
    chk("t1_stall_len", low_cnt, 3);
    chk("t1_bubbles", bub_cnt, 3);
    chk("t1_stall_cycles", stall_cycles, 3);
    idle(); repeat (3) step();

    // 2: r0 as destination and source never stalls
    clr();
    id_valid = 1; id_rd = 0; id_rd_valid = 1; step();
    id_rd_valid = 0; id_rs1 = 3; id_rs2 = 0; repeat (2) step();
    chk("t2_no_stall", low_cnt, 0);
    idle(); repeat (3) step();

    // 3: memory wait in the middle of a hazard: 1 + 4 + 2 stalled cycles
    clr();
    id_valid = 1; id_rd = 5; id_rd_valid = 1; step();
    id_rd = 0; id_rd_valid = 0; id_rs1 = 5; step();
    mem_busy = 1; repeat (4) step();
    mem_busy = 0; repeat (3) step();
    chk("t3_stall_len", low_cnt, 7);
    chk("t3_mwb_bubbles", mwb_cnt, 4);
    chk("t3_state_memwait", st2_cnt, 4);
    idle(); repeat (3) step();

    // 4: redirect wins over a hazard and kills the decode instruction
    clr();
    id_valid = 1; id_rd = 6; id_rd_valid = 1; step();
    id_rs1 = 6; id_rd = 7; id_rd_valid = 1; exe_redirect = 1; #1;
    chk("t4_pc_en", pc_en, 1);
    chk("t4_if_id_flush", if_id_flush, 1);
    step();
    exe_redirect = 0; id_rd = 0; id_rd_valid = 0; id_rs1 = 7; repeat (3) step();
    chk("t4_flush_cnt", fl_cnt, 1);
    chk("t4_killed_no_stall", low_cnt, 0);
    idle(); repeat (3) step();

    // 5: redirect during memory wait is deferred to the first free cycle
    clr();
    mem_busy = 1; exe_redirect = 1; #1;
    chk("t5_no_flush_busy", flush, 0);
    step();
    exe_redirect = 0; step();
    mem_busy = 0; #1;
    chk("t5_flush_release", flush, 1);
    step();
    repeat (2) step();
    chk("t5_flush_once", fl_cnt, 1);
    idle(); repeat (2) step();

    // 6: counter saturation, then reset in the middle of a hazard stall
    mem_busy = 1; repeat (65540) step();
    mem_busy = 0;
    chk("t6_saturated", stall_cycles, 16'hFFFF);
    idle(); repeat (3) step();
    id_valid = 1; id_rd = 9; id_rd_valid = 1; step();
    id_rd = 0; id_rd_valid = 0; id_rs1 = 9; #2;
    chk("t6_stalled", pc_en, 0);
    rst_n = 0; #1;
    chk("t6_rst_cnt", stall_cycles, 0);
    chk("t6_rst_pc_en", pc_en, 1);
    chk("t6_rst_state", ctrl_state, 0);
    step();
    rst_n = 1;
    step();
    #1;
    chk("t6_tags_cleared", pc_en, 1);
    idle(); repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
